// File: rtl/id_ex_pipe_pkg.sv
// Shared constants for the ID/EX pipeline register: PC width, RV32 major opcodes
// and the bubble opcode that EX sees when no instruction is held.
package id_ex_pipe_pkg;

    localparam int PC_WIDTH = 32;

    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/id_ex_pipe_slot.sv
// One storage entry holding every decoded instruction field; loads on 'load',
// clears to zero on asynchronous active-low reset.
module id_ex_slot #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PC_W-1:0]   pc_d,
    input  logic [6:0]        opcode_d,
    input  logic [6:0]        funct7_d,
    input  logic [2:0]        funct3_d,
    input  logic [DATA_W-1:0] imm_d,
    input  logic [DATA_W-1:0] rs1_data_d,
    input  logic [DATA_W-1:0] rs2_data_d,
    input  logic              rd_we_d,
    input  logic [4:0]        rd_addr_d,
    output logic [PC_W-1:0]   pc_q,
    output logic [6:0]        opcode_q,
    output logic [6:0]        funct7_q,
    output logic [2:0]        funct3_q,
    output logic [DATA_W-1:0] imm_q,
    output logic [DATA_W-1:0] rs1_data_q,
    output logic [DATA_W-1:0] rs2_data_q,
    output logic              rd_we_q,
    output logic [4:0]        rd_addr_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            opcode_q   <= '0;
            funct7_q   <= '0;
            funct3_q   <= '0;
            imm_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
        end else if (load) begin
            pc_q       <= pc_d;
            opcode_q   <= opcode_d;
            funct7_q   <= funct7_d;
            funct3_q   <= funct3_d;
            imm_q      <= imm_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_we_q    <= rd_we_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshake, synchronous flush and bubble forcing.
// Define ID_EX_SKID_EN for the registered-ready two-entry (MAIN + SKID) variant.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int PC_W   = PC_WIDTH,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [6:0]        opcode_i,
    input  logic [6:0]        funct7_i,
    input  logic [2:0]        funct3_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic              rd_we_i,
    input  logic [4:0]        rd_addr_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [6:0]        opcode_o,
    output logic [6:0]        funct7_o,
    output logic [2:0]        funct3_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    output logic              rd_we_o,
    output logic [4:0]        rd_addr_o
);

`ifdef ID_EX_SKID_EN
    typedef enum logic [1:0] {S_EMPTY, S_BUSY, S_FULL} state_t;
`else
    typedef enum logic [1:0] {S_EMPTY, S_BUSY} state_t;
`endif

    state_t state, state_nxt;
    logic   in_fire, out_fire;
    logic   main_load;

    logic [PC_W-1:0]   main_pc_d,       main_pc_q;
    logic [6:0]        main_opcode_d,   main_opcode_q;
    logic [6:0]        main_funct7_d,   main_funct7_q;
    logic [2:0]        main_funct3_d,   main_funct3_q;
    logic [DATA_W-1:0] main_imm_d,      main_imm_q;
    logic [DATA_W-1:0] main_rs1_data_d, main_rs1_data_q;
    logic [DATA_W-1:0] main_rs2_data_d, main_rs2_data_q;
    logic              main_rd_we_d,    main_rd_we_q;
    logic [4:0]        main_rd_addr_d,  main_rd_addr_q;

    assign valid_o  = (state != S_EMPTY);
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

`ifdef ID_EX_SKID_EN
    logic skid_load, main_from_skid;

    logic [PC_W-1:0]   skid_pc_q;
    logic [6:0]        skid_opcode_q;
    logic [6:0]        skid_funct7_q;
    logic [2:0]        skid_funct3_q;
    logic [DATA_W-1:0] skid_imm_q;
    logic [DATA_W-1:0] skid_rs1_data_q;
    logic [DATA_W-1:0] skid_rs2_data_q;
    logic              skid_rd_we_q;
    logic [4:0]        skid_rd_addr_q;

    // Registered ready: no combinational path from ready_i back to ID.
    assign ready_o = (state != S_FULL);

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = S_BUSY;
                        main_load = 1'b1;
                    end
                end
                S_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = S_FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_nxt      = S_BUSY;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    assign main_pc_d       = main_from_skid ? skid_pc_q       : pc_i;
    assign main_opcode_d   = main_from_skid ? skid_opcode_q   : opcode_i;
    assign main_funct7_d   = main_from_skid ? skid_funct7_q   : funct7_i;
    assign main_funct3_d   = main_from_skid ? skid_funct3_q   : funct3_i;
    assign main_imm_d      = main_from_skid ? skid_imm_q      : imm_i;
    assign main_rs1_data_d = main_from_skid ? skid_rs1_data_q : rs1_data_i;
    assign main_rs2_data_d = main_from_skid ? skid_rs2_data_q : rs2_data_i;
    assign main_rd_we_d    = main_from_skid ? skid_rd_we_q    : rd_we_i;
    assign main_rd_addr_d  = main_from_skid ? skid_rd_addr_q  : rd_addr_i;

    id_ex_slot #(.PC_W(PC_W), .DATA_W(DATA_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .pc_d       (pc_i),
        .opcode_d   (opcode_i),
        .funct7_d   (funct7_i),
        .funct3_d   (funct3_i),
        .imm_d      (imm_i),
        .rs1_data_d (rs1_data_i),
        .rs2_data_d (rs2_data_i),
        .rd_we_d    (rd_we_i),
        .rd_addr_d  (rd_addr_i),
        .pc_q       (skid_pc_q),
        .opcode_q   (skid_opcode_q),
        .funct7_q   (skid_funct7_q),
        .funct3_q   (skid_funct3_q),
        .imm_q      (skid_imm_q),
        .rs1_data_q (skid_rs1_data_q),
        .rs2_data_q (skid_rs2_data_q),
        .rd_we_q    (skid_rd_we_q),
        .rd_addr_q  (skid_rd_addr_q)
    );
`else
    // Single entry: accept a new beat only when the held one leaves this cycle.
    assign ready_o = ~valid_o | ready_i;

    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        if (flush_i) begin
            state_nxt = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = S_BUSY;
                        main_load = 1'b1;
                    end
                end
                S_BUSY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = S_EMPTY;
                    end
                end
                default: state_nxt = S_EMPTY;
            endcase
        end
    end

    assign main_pc_d       = pc_i;
    assign main_opcode_d   = opcode_i;
    assign main_funct7_d   = funct7_i;
    assign main_funct3_d   = funct3_i;
    assign main_imm_d      = imm_i;
    assign main_rs1_data_d = rs1_data_i;
    assign main_rs2_data_d = rs2_data_i;
    assign main_rd_we_d    = rd_we_i;
    assign main_rd_addr_d  = rd_addr_i;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_EMPTY;
        else      state <= state_nxt;
    end

    id_ex_slot #(.PC_W(PC_W), .DATA_W(DATA_W)) u_main (
        .clk        (clk),
        .rst        (rst),
        .load       (main_load),
        .pc_d       (main_pc_d),
        .opcode_d   (main_opcode_d),
        .funct7_d   (main_funct7_d),
        .funct3_d   (main_funct3_d),
        .imm_d      (main_imm_d),
        .rs1_data_d (main_rs1_data_d),
        .rs2_data_d (main_rs2_data_d),
        .rd_we_d    (main_rd_we_d),
        .rd_addr_d  (main_rd_addr_d),
        .pc_q       (main_pc_q),
        .opcode_q   (main_opcode_q),
        .funct7_q   (main_funct7_q),
        .funct3_q   (main_funct3_q),
        .imm_q      (main_imm_q),
        .rs1_data_q (main_rs1_data_q),
        .rs2_data_q (main_rs2_data_q),
        .rd_we_q    (main_rd_we_q),
        .rd_addr_q  (main_rd_addr_q)
    );

    // Bubble: EX must see a harmless NOP that never writes the register file.
    assign opcode_o   = valid_o ? main_opcode_q : OP_NOP;
    assign funct7_o   = valid_o ? main_funct7_q : 7'd0;
    assign funct3_o   = valid_o ? main_funct3_q : 3'd0;
    assign rd_we_o    = valid_o & main_rd_we_q;
    assign pc_o       = main_pc_q;
    assign imm_o      = main_imm_q;
    assign rs1_data_o = main_rs1_data_q;
    assign rs2_data_o = main_rs2_data_q;
    assign rd_addr_o  = main_rd_addr_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: a FIFO-occupancy model predicts ready/valid and the
// order of presented instructions; a separate monitor pops and compares on each output.
module tb_id_ex_pipe;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        rd_we;
        logic [4:0]  rd_addr;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] pc_i = '0;
    logic [6:0]  opcode_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] imm_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        rd_we_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [6:0]  opcode_o;
    logic [6:0]  funct7_o;
    logic [2:0]  funct3_o;
    logic [31:0] imm_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .opcode_i(opcode_i), .funct7_i(funct7_i), .funct3_i(funct3_i),
        .imm_i(imm_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .pc_o(pc_o), .opcode_o(opcode_o), .funct7_o(funct7_o), .funct3_o(funct3_o),
        .imm_o(imm_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o)
    );

    always #5 clk = ~clk;

`ifdef ID_EX_SKID_EN
    localparam int CAPACITY = 2;
`else
    localparam int CAPACITY = 1;
`endif

    int     errors = 0;
    int     checks = 0;
    instr_t exp_q[$];
    int     held = 0;
    bit     seen_30 = 1'b0;
    logic   last_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occupancy-based ready prediction and FIFO of accepted, unflushed beats.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            held = 0;
            exp_q.delete();
            chk("reset_valid_o", 64'(valid_o), 64'd0);
            chk("reset_ready_o", 64'(ready_o), 64'd1);
            chk("reset_opcode_o", 64'(opcode_o), 64'd0);
            chk("reset_rd_we_o", 64'(rd_we_o), 64'd0);
        end else begin
            bit exp_ready, inf, outf;
            instr_t t;
            exp_ready = (CAPACITY == 2) ? (held < 2) : (held == 0 || ready_i);
            chk("ready_o", 64'(ready_o), 64'(exp_ready));
            inf  = valid_i && exp_ready;
            outf = (held > 0) && ready_i;
            if (flush_i) begin
                held = 0;
                exp_q.delete();
            end else begin
                held = held + int'(inf) - int'(outf);
                if (inf) begin
                    t.pc = pc_i; t.opcode = opcode_i; t.funct7 = funct7_i;
                    t.funct3 = funct3_i; t.imm = imm_i; t.rs1 = rs1_data_i;
                    t.rs2 = rs2_data_i; t.rd_we = rd_we_i; t.rd_addr = rd_addr_i;
                    exp_q.push_back(t);
                end
            end
        end
    end

    // Monitor: compares what EX sees against the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            chk("valid_o", 64'(valid_o), 64'(exp_q.size() != 0));
            if (valid_o && pc_o == 32'h30) seen_30 = 1'b1;
            if (valid_o && exp_q.size() != 0) begin
                chk("pc_o", 64'(pc_o), 64'(exp_q[0].pc));
                chk("opcode_o", 64'(opcode_o), 64'(exp_q[0].opcode));
                chk("funct7_o", 64'(funct7_o), 64'(exp_q[0].funct7));
                chk("funct3_o", 64'(funct3_o), 64'(exp_q[0].funct3));
                chk("imm_o", 64'(imm_o), 64'(exp_q[0].imm));
                chk("rs1_data_o", 64'(rs1_data_o), 64'(exp_q[0].rs1));
                chk("rs2_data_o", 64'(rs2_data_o), 64'(exp_q[0].rs2));
                chk("rd_we_o", 64'(rd_we_o), 64'(exp_q[0].rd_we));
                chk("rd_addr_o", 64'(rd_addr_o), 64'(exp_q[0].rd_addr));
                if (ready_i) void'(exp_q.pop_front());
            end else if (!valid_o) begin
                chk("bubble_opcode", 64'(opcode_o), 64'd0);
                chk("bubble_funct7", 64'(funct7_o), 64'd0);
                chk("bubble_funct3", 64'(funct3_o), 64'd0);
                chk("bubble_rd_we", 64'(rd_we_o), 64'd0);
            end
        end
    end

    function automatic instr_t rand_instr(input logic [31:0] pc);
        instr_t t;
        t.pc      = pc;
        t.opcode  = 7'($urandom);
        t.funct7  = 7'($urandom);
        t.funct3  = 3'($urandom);
        t.imm     = $urandom;
        t.rs1     = $urandom;
        t.rs2     = $urandom;
        t.rd_we   = 1'($urandom);
        t.rd_addr = 5'($urandom);
        return t;
    endfunction

    task automatic apply(input instr_t t);
        pc_i = t.pc; opcode_i = t.opcode; funct7_i = t.funct7; funct3_i = t.funct3;
        imm_i = t.imm; rs1_data_i = t.rs1; rs2_data_i = t.rs2;
        rd_we_i = t.rd_we; rd_addr_i = t.rd_addr;
    endtask

    task automatic step();
        @(negedge clk);
        last_ready = ready_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // Offers each beat until accepted; ready_i is held low for the first 'stall' cycles.
    task automatic stream(input instr_t beats[$], input int stall);
        int idx = 0;
        int cyc = 0;
        while (idx < beats.size() && cyc < 60) begin
            ready_i = (cyc >= stall);
            apply(beats[idx]);
            valid_i = 1'b1;
            step();
            if (last_ready) idx++;
            cyc++;
        end
        valid_i = 1'b0;
        chk("stream_all_accepted", 64'(idx), 64'(beats.size()));
    endtask

    initial begin
        instr_t beats[$];
        instr_t t;
        int     drain;

        // Reset held while ID offers a beat: nothing may be captured.
        apply(rand_instr(32'h10));
        valid_i = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        valid_i = 1'b0;
        step();

        // Single addi beat.
        t = rand_instr(32'h40);
        t.opcode = 7'h13; t.imm = 32'd5; t.rd_addr = 5'd3; t.rd_we = 1'b1;
        beats = '{t};
        stream(beats, 0);
        idle(3);

        // Back-to-back streaming.
        beats = '{rand_instr(32'h10), rand_instr(32'h14), rand_instr(32'h18)};
        stream(beats, 0);
        idle(3);

        // Backpressure with three beats.
        beats = '{rand_instr(32'h20), rand_instr(32'h24), rand_instr(32'h28)};
        stream(beats, 4);
        idle(4);

        // Flush with the stage as full as it gets; 0x30 must never emerge.
        ready_i = 1'b0;
        apply(rand_instr(32'h50)); valid_i = 1'b1; step();
        apply(rand_instr(32'h54)); step();
        apply(rand_instr(32'h30)); flush_i = 1'b1; step();
        flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        idle(3);

        // Asynchronous reset between edges while BUSY.
        ready_i = 1'b0;
        apply(rand_instr(32'h60)); valid_i = 1'b1; step();
        valid_i = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("async_rst_valid_o", 64'(valid_o), 64'd0);
        chk("async_rst_ready_o", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        beats = '{rand_instr(32'h64)};
        stream(beats, 0);
        idle(3);

        // Randomized traffic with random backpressure and occasional flushes.
        valid_i = 1'b0;
        last_ready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            if (!valid_i || last_ready || flush_i) begin
                apply(rand_instr(32'h1000 + ($urandom_range(0, 4095) << 2)));
                valid_i = ($urandom_range(0, 3) != 0);
            end
            flush_i = ($urandom_range(0, 24) == 0);
            step();
        end

        idle(1);
        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            step();
            drain++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("flushed_0x30_absent", 64'(seen_30), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
